// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- HI/LO multiply/divide unit controller.
//
// Owns the HI and LO registers. MULT/MULTU operands are registered towards an
// external two-cycle multiplier, whose product is written into {hi,lo}.
// DIV/DIVU use an internal restoring divider that produces one quotient bit
// per cycle over 32 cycles. MTHI/MTLO write HI/LO directly. MFHI/MFLO are
// served combinationally through hilo_rdata.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   in_valid             EX-stage instruction valid and not flushed
//   mult/div/mfhl/mthl   one-hot-per-field op decode; bit0 wins if both set
//   op_a, op_b           rs / rt values
//   mul_a, mul_b         registered multiplier operands
//   mul_signed           signed multiply select
//   mul_prod             external multiplier product
//   hilo_rdata           MFHI/MFLO read data
//   hi, lo               committed HI/LO registers
//   busy                 a multiply or divide is in flight
//   stall                hold the EX stage
//
// Handshake: an op is taken at a rising edge when the FSM is IDLE and
// in_valid=1; while busy, any valid HI/LO-related instruction is held with
// stall=1 and is then taken or served in the first IDLE cycle, which already
// sees the HI/LO result of the preceding op.
module mdu_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [1:0]  mult,
  input  logic [1:0]  div,
  input  logic [1:0]  mfhl,
  input  logic [1:0]  mthl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_prod,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;     // MUL: 0..1, DIV: 0..31
  logic [31:0] rem_q;     // partial remainder (magnitude)
  logic [31:0] quo_q;     // dividend bits shifting out, quotient bits shifting in
  logic [31:0] dvs_q;     // divisor magnitude
  logic        neg_q_q;   // negate quotient at the end
  logic        neg_r_q;   // negate remainder at the end
  logic        dvz_q;     // divisor was zero

  // Operand magnitudes for the divider; only DIV treats operands as signed.
  logic        div_sgn;
  logic [31:0] mag_a, mag_b;
  assign div_sgn = div[0];
  assign mag_a   = (div_sgn && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign mag_b   = (div_sgn && op_b[31]) ? (~op_b + 32'd1) : op_b;

  // One restoring step. The shifted remainder needs 33 bits, but when the
  // divisor fits the difference is below 2^32, so 32-bit subtraction is exact.
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] diff, rem_nx, quo_nx, q_fin, r_fin;
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    fits   = (rem_sh >= {1'b0, dvs_q});
    diff   = rem_sh[31:0] - dvs_q;
    rem_nx = fits ? diff : rem_sh[31:0];
    quo_nx = {quo_q[30:0], fits};
    q_fin  = neg_q_q ? (~quo_nx + 32'd1) : quo_nx;
    // With a zero divisor the remainder ends equal to |op_a|, so re-applying
    // the dividend sign returns op_a unchanged.
    r_fin  = neg_r_q ? (~rem_nx + 32'd1) : rem_nx;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && (|mult))     state_d = S_MUL;
        else if (in_valid && (|div)) state_d = S_DIV;
      end
      S_MUL:   if (cnt_q == 6'd1)  state_d = S_IDLE;
      S_DIV:   if (cnt_q == 6'd31) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath and HI/LO registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi         <= '0;
      lo         <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      dvz_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (|mult) begin
              mul_a      <= op_a;
              mul_b      <= op_b;
              mul_signed <= mult[0];
              cnt_q      <= '0;
            end else if (|div) begin
              dvs_q   <= mag_b;
              quo_q   <= mag_a;
              rem_q   <= '0;
              neg_q_q <= div_sgn & (op_a[31] ^ op_b[31]);
              neg_r_q <= div_sgn & op_a[31];
              dvz_q   <= (op_b == 32'd0);
              cnt_q   <= '0;
            end else if (mthl[0]) begin
              lo <= op_a;
            end else if (mthl[1]) begin
              hi <= op_a;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == 6'd1) begin
            {hi, lo} <= mul_prod;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DIV: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (cnt_q == 6'd31) begin
            hi    <= r_fin;
            lo    <= dvz_q ? 32'hFFFF_FFFF : q_fin;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign stall      = in_valid & busy & ((|mult) | (|div) | (|mfhl) | (|mthl));
  // MFLO wins when both read bits are set.
  assign hilo_rdata = (mfhl[1] && !mfhl[0]) ? hi : lo;

endmodule
